// File: rtl/parametric_speculative_switch_allocator.sv
// Separable input-first switch allocator with parallel speculative path,
// non-speculative priority merge and per-output/per-VC credit counters.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   nonspec_req_i     : [port][vc] VC holds a downstream VC and a ready flit
//   spec_req_i        : [port][vc] VC requests a switch speculatively
//   out_port_i        : [port][vc] routed output port
//   downstream_vc_i   : [port][vc] downstream VC for non-spec requests
//   va_grant_i        : [port][vc] VA success this cycle
//   va_vc_i           : [port][vc] downstream VC assigned by VA
//   credit_i          : [out][vc] one credit returned
//   valid_sel_o       : [in] input forwards a flit
//   vc_sel_o          : [in] VC selected at each input
//   input_vc_sel_o    : [out] crossbar select per output
//   valid_flit_o      : [out] flit valid toward downstream router
//   flit_vc_o         : [out] downstream VC of the flit
module parametric_speculative_switch_allocator #(
    parameter int PORT_NUM     = 5,
    parameter int VC_NUM       = 2,
    parameter int BUFFER_DEPTH = 4,
    parameter int OUTPUT_REG   = 1,
    localparam int PORT_SIZE   = $clog2(PORT_NUM),
    localparam int VC_SIZE     = $clog2(VC_NUM),
    localparam int CREDIT_W    = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                nonspec_req_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                spec_req_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                va_grant_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   va_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                credit_i,
    output logic [PORT_NUM-1:0]                            valid_sel_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]             input_vc_sel_o,
    output logic [PORT_NUM-1:0]                            valid_flit_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]               flit_vc_o
);

    logic [CREDIT_W-1:0]  cnt [PORT_NUM][VC_NUM];
    logic [VC_SIZE-1:0]   ns_vc_ptr [PORT_NUM];
    logic [VC_SIZE-1:0]   sp_vc_ptr [PORT_NUM];
    logic [PORT_SIZE-1:0] ns_in_ptr [PORT_NUM];
    logic [PORT_SIZE-1:0] sp_in_ptr [PORT_NUM];

    logic [VC_NUM-1:0]    ns_elig [PORT_NUM];
    logic [VC_NUM-1:0]    sp_elig [PORT_NUM];
    logic                 ns_v [PORT_NUM], sp_v [PORT_NUM];
    logic [VC_SIZE-1:0]   ns_vc [PORT_NUM], sp_vc [PORT_NUM];
    logic [PORT_SIZE-1:0] ns_op [PORT_NUM], sp_op [PORT_NUM];
    logic                 ns_g [PORT_NUM], sp_g [PORT_NUM];
    logic [PORT_SIZE-1:0] ns_gi [PORT_NUM], sp_gi [PORT_NUM];
    logic                 ns_row [PORT_NUM];
    logic                 sp_ok [PORT_NUM];
    logic                 fin_v [PORT_NUM];
    logic [PORT_SIZE-1:0] fin_in [PORT_NUM];
    logic [VC_SIZE-1:0]   fin_vc [PORT_NUM];
    logic [VC_SIZE-1:0]   fin_dvc [PORT_NUM];
    logic [VC_NUM-1:0]    cnt_dec [PORT_NUM];

    logic [PORT_NUM-1:0]                valid_sel_d, valid_flit_d;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel_d, flit_vc_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] input_vc_sel_d;

    function automatic int wrap_add(input int b, input int k, input int n);
        return (b + k >= n) ? b + k - n : b + k;
    endfunction

    function automatic logic [PORT_SIZE-1:0] nxt_port(input logic [PORT_SIZE-1:0] p);
        return (int'(p) == PORT_NUM - 1) ? '0 : p + PORT_SIZE'(1);
    endfunction

    function automatic logic [VC_SIZE-1:0] nxt_vc(input logic [VC_SIZE-1:0] v);
        return (int'(v) == VC_NUM - 1) ? '0 : v + VC_SIZE'(1);
    endfunction

    // Eligibility and stage 1: one VC per input for each class.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            ns_v[i]  = 1'b0;
            sp_v[i]  = 1'b0;
            ns_vc[i] = '0;
            sp_vc[i] = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                ns_elig[i][v] = nonspec_req_i[i][v] &&
                    cnt[out_port_i[i][v]][downstream_vc_i[i][v]] != '0;
                sp_elig[i][v] = spec_req_i[i][v] && !nonspec_req_i[i][v];
            end
            for (int k = 0; k < VC_NUM; k++) begin
                if (!ns_v[i] && ns_elig[i][wrap_add(int'(ns_vc_ptr[i]), k, VC_NUM)]) begin
                    ns_v[i]  = 1'b1;
                    ns_vc[i] = VC_SIZE'(wrap_add(int'(ns_vc_ptr[i]), k, VC_NUM));
                end
                if (!sp_v[i] && sp_elig[i][wrap_add(int'(sp_vc_ptr[i]), k, VC_NUM)]) begin
                    sp_v[i]  = 1'b1;
                    sp_vc[i] = VC_SIZE'(wrap_add(int'(sp_vc_ptr[i]), k, VC_NUM));
                end
            end
            ns_op[i] = out_port_i[i][ns_vc[i]];
            sp_op[i] = out_port_i[i][sp_vc[i]];
        end
    end

    // Stage 2: one input per output for each class.
    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            ns_g[o]  = 1'b0;
            sp_g[o]  = 1'b0;
            ns_gi[o] = '0;
            sp_gi[o] = '0;
            for (int k = 0; k < PORT_NUM; k++) begin
                if (!ns_g[o] && ns_v[wrap_add(int'(ns_in_ptr[o]), k, PORT_NUM)] &&
                    ns_op[wrap_add(int'(ns_in_ptr[o]), k, PORT_NUM)] == PORT_SIZE'(o)) begin
                    ns_g[o]  = 1'b1;
                    ns_gi[o] = PORT_SIZE'(wrap_add(int'(ns_in_ptr[o]), k, PORT_NUM));
                end
                if (!sp_g[o] && sp_v[wrap_add(int'(sp_in_ptr[o]), k, PORT_NUM)] &&
                    sp_op[wrap_add(int'(sp_in_ptr[o]), k, PORT_NUM)] == PORT_SIZE'(o)) begin
                    sp_g[o]  = 1'b1;
                    sp_gi[o] = PORT_SIZE'(wrap_add(int'(sp_in_ptr[o]), k, PORT_NUM));
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            ns_row[i] = 1'b0;
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            if (ns_g[o]) begin
                ns_row[ns_gi[o]] = 1'b1;
            end
        end
    end

    // Merge: spec survives only on a free row and column with VA and credit.
    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            sp_ok[o] = sp_g[o] && !ns_g[o] && !ns_row[sp_gi[o]] &&
                va_grant_i[sp_gi[o]][sp_vc[sp_gi[o]]] &&
                cnt[o][va_vc_i[sp_gi[o]][sp_vc[sp_gi[o]]]] != '0;
            fin_v[o]   = 1'b0;
            fin_in[o]  = '0;
            fin_vc[o]  = '0;
            fin_dvc[o] = '0;
            if (ns_g[o]) begin
                fin_v[o]   = 1'b1;
                fin_in[o]  = ns_gi[o];
                fin_vc[o]  = ns_vc[ns_gi[o]];
                fin_dvc[o] = downstream_vc_i[ns_gi[o]][ns_vc[ns_gi[o]]];
            end else if (sp_ok[o]) begin
                fin_v[o]   = 1'b1;
                fin_in[o]  = sp_gi[o];
                fin_vc[o]  = sp_vc[sp_gi[o]];
                fin_dvc[o] = va_vc_i[sp_gi[o]][sp_vc[sp_gi[o]]];
            end
            for (int d = 0; d < VC_NUM; d++) begin
                cnt_dec[o][d] = fin_v[o] && fin_dvc[o] == VC_SIZE'(d);
            end
        end
    end

    always_comb begin
        valid_sel_d    = '0;
        vc_sel_d       = '0;
        valid_flit_d   = '0;
        input_vc_sel_d = '0;
        flit_vc_d      = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (fin_v[o]) begin
                valid_flit_d[o]          = 1'b1;
                input_vc_sel_d[o]        = fin_in[o];
                flit_vc_d[o]             = fin_dvc[o];
                valid_sel_d[fin_in[o]]   = 1'b1;
                vc_sel_d[fin_in[o]]      = fin_vc[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                ns_vc_ptr[p] <= '0;
                sp_vc_ptr[p] <= '0;
                ns_in_ptr[p] <= '0;
                sp_in_ptr[p] <= '0;
                for (int d = 0; d < VC_NUM; d++) begin
                    cnt[p][d] <= CREDIT_W'(BUFFER_DEPTH);
                end
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (ns_g[o]) begin
                    ns_in_ptr[o]        <= nxt_port(ns_gi[o]);
                    ns_vc_ptr[ns_gi[o]] <= nxt_vc(ns_vc[ns_gi[o]]);
                end
                if (sp_ok[o]) begin
                    sp_in_ptr[o]        <= nxt_port(sp_gi[o]);
                    sp_vc_ptr[sp_gi[o]] <= nxt_vc(sp_vc[sp_gi[o]]);
                end
                for (int d = 0; d < VC_NUM; d++) begin
                    if (cnt_dec[o][d] && !credit_i[o][d] && cnt[o][d] != '0) begin
                        cnt[o][d] <= cnt[o][d] - CREDIT_W'(1);
                    end else if (!cnt_dec[o][d] && credit_i[o][d] &&
                                 cnt[o][d] != CREDIT_W'(BUFFER_DEPTH)) begin
                        cnt[o][d] <= cnt[o][d] + CREDIT_W'(1);
                    end
                end
            end
        end
    end

    // A credit returned to a full counter means the downstream lost track.
    always_ff @(posedge clk) begin
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int d = 0; d < VC_NUM; d++) begin
                if (rst && credit_i[o][d] && !cnt_dec[o][d]) begin
                    assert (cnt[o][d] != CREDIT_W'(BUFFER_DEPTH));
                end
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_sel_o    <= '0;
                vc_sel_o       <= '0;
                input_vc_sel_o <= '0;
                valid_flit_o   <= '0;
                flit_vc_o      <= '0;
            end else begin
                valid_sel_o    <= valid_sel_d;
                vc_sel_o       <= vc_sel_d;
                input_vc_sel_o <= input_vc_sel_d;
                valid_flit_o   <= valid_flit_d;
                flit_vc_o      <= flit_vc_d;
            end
        end
    end else begin : g_comb
        assign valid_sel_o    = valid_sel_d;
        assign vc_sel_o       = vc_sel_d;
        assign input_vc_sel_o = input_vc_sel_d;
        assign valid_flit_o   = valid_flit_d;
        assign flit_vc_o      = flit_vc_d;
    end

endmodule

// File: tb/tb_parametric_speculative_switch_allocator.sv
// Directed bench for the speculative switch allocator (registered outputs).
// Vectors with hand-derived expected grants, selects and credit behaviour.
module tb_parametric_speculative_switch_allocator;

    logic clk = 1'b0;
    logic rst;
    logic [4:0][1:0]       nonspec_req, spec_req, va_grant, credit;
    logic [4:0][1:0][2:0]  out_port;
    logic [4:0][1:0][0:0]  dvc, va_vc;
    logic [4:0]            valid_sel, valid_flit;
    logic [4:0][0:0]       vc_sel, flit_vc;
    logic [4:0][2:0]       input_vc_sel;

    int n_cmp = 0;
    int n_bad = 0;

    parametric_speculative_switch_allocator #(
        .PORT_NUM(5), .VC_NUM(2), .BUFFER_DEPTH(4), .OUTPUT_REG(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .nonspec_req_i(nonspec_req),
        .spec_req_i(spec_req),
        .out_port_i(out_port),
        .downstream_vc_i(dvc),
        .va_grant_i(va_grant),
        .va_vc_i(va_vc),
        .credit_i(credit),
        .valid_sel_o(valid_sel),
        .vc_sel_o(vc_sel),
        .input_vc_sel_o(input_vc_sel),
        .valid_flit_o(valid_flit),
        .flit_vc_o(flit_vc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        nonspec_req = '0;
        spec_req    = '0;
        va_grant    = '0;
        credit      = '0;
        out_port    = '0;
        dvc         = '0;
        va_vc       = '0;
    endtask

    initial begin
        clear();
        rst = 1'b0;
        nonspec_req = '1;
        spec_req    = '1;
        va_grant    = '1;
        for (int i = 0; i < 5; i++) begin
            out_port[i][0] = 3'd1;
            out_port[i][1] = 3'd1;
        end
        step();
        step();
        chk("rst_valid_sel", 32'(valid_sel), 32'h0);
        chk("rst_valid_flit", 32'(valid_flit), 32'h0);
        chk("rst_in_sel", 32'(input_vc_sel), 32'h0);
        chk("rst_flit_vc", 32'(flit_vc), 32'h0);
        chk("rst_vc_sel", 32'(vc_sel), 32'h0);

        // out1/vc0 from in0: four credits then blocked
        clear();
        nonspec_req[0][0] = 1'b1;
        out_port[0][0]    = 3'd1;
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("post_rst_flit", 32'(valid_flit), 32'h02);
            chk("post_rst_sel", 32'(valid_sel), 32'h01);
        end
        step();
        chk("post_rst_blocked", 32'(valid_flit), 32'h0);

        // Non-spec fairness on out3
        clear();
        nonspec_req[0][0] = 1'b1;
        nonspec_req[2][0] = 1'b1;
        out_port[0][0]    = 3'd3;
        out_port[2][0]    = 3'd3;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("fair_flit", 32'(valid_flit), 32'h08);
            chk("fair_in_sel", 32'(input_vc_sel[3]), (n % 2 == 0) ? 32'd0 : 32'd2);
        end

        // Spec loses column to non-spec
        clear();
        nonspec_req[1][0] = 1'b1;
        out_port[1][0]    = 3'd2;
        spec_req[3][0]    = 1'b1;
        out_port[3][0]    = 3'd2;
        va_grant[3][0]    = 1'b1;
        va_vc[3][0]       = 1'b1;
        step();
        chk("mix_flit", 32'(valid_flit), 32'h04);
        chk("mix_sel", 32'(valid_sel), 32'h02);
        chk("mix_in_sel2", 32'(input_vc_sel[2]), 32'd1);

        // Spec retargeted to a free output
        out_port[3][0] = 3'd4;
        step();
        chk("both_flit", 32'(valid_flit), 32'h14);
        chk("both_sel", 32'(valid_sel), 32'h0a);
        chk("both_in_sel4", 32'(input_vc_sel[4]), 32'd3);
        chk("both_flit_vc4", 32'(flit_vc[4]), 32'd1);
        chk("both_flit_vc2", 32'(flit_vc[2]), 32'd0);

        // Spec without VA is dropped
        clear();
        spec_req[4][1] = 1'b1;
        va_vc[4][1]    = 1'b1;
        step();
        chk("nova_flit", 32'(valid_flit), 32'h0);
        va_grant[4][1] = 1'b1;
        step();
        chk("va_flit", 32'(valid_flit), 32'h01);
        chk("va_vc_sel", 32'(vc_sel[4]), 32'd1);
        chk("va_in_sel0", 32'(input_vc_sel[0]), 32'd4);
        chk("va_flit_vc0", 32'(flit_vc[0]), 32'd1);

        // Spec pointer now at vc0; a dropped vc0 grant must not advance it
        spec_req[4][0] = 1'b1;
        va_grant[4][0] = 1'b0;
        step();
        chk("drop_flit", 32'(valid_flit), 32'h0);
        va_grant[4][0] = 1'b1;
        step();
        chk("keep_ptr_vc", 32'(vc_sel[4]), 32'd0);
        chk("keep_ptr_flit", 32'(valid_flit), 32'h01);

        // Credit exhaustion on out1/vc1
        clear();
        nonspec_req[2][1] = 1'b1;
        out_port[2][1]    = 3'd1;
        dvc[2][1]         = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("cred_grant", 32'(valid_flit), 32'h02);
            chk("cred_flit_vc", 32'(flit_vc[1]), 32'd1);
        end
        step();
        chk("cred_blocked", 32'(valid_flit), 32'h0);
        credit[1][1] = 1'b1;
        step();
        chk("cred_ret_cycle", 32'(valid_flit), 32'h0);
        credit[1][1] = 1'b0;
        step();
        chk("cred_regrant", 32'(valid_flit), 32'h02);
        credit[1][1] = 1'b1;
        step();
        chk("cred_ret2", 32'(valid_flit), 32'h0);
        step();
        chk("cred_both", 32'(valid_flit), 32'h02);
        credit[1][1] = 1'b0;
        step();
        chk("cred_after_both", 32'(valid_flit), 32'h02);
        step();
        chk("cred_empty", 32'(valid_flit), 32'h0);

        // Mid-operation reset on out3/vc1 stream
        clear();
        nonspec_req[0][0] = 1'b1;
        nonspec_req[2][0] = 1'b1;
        out_port[0][0]    = 3'd3;
        out_port[2][0]    = 3'd3;
        dvc[0][0]         = 1'b1;
        dvc[2][0]         = 1'b1;
        step();
        chk("mid_first", 32'(input_vc_sel[3]), 32'd0);
        rst = 1'b0;
        step();
        chk("mid_rst_flit", 32'(valid_flit), 32'h0);
        chk("mid_rst_sel", 32'(valid_sel), 32'h0);
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("mid_flit", 32'(valid_flit), 32'h08);
            chk("mid_in_sel", 32'(input_vc_sel[3]), (n % 2 == 0) ? 32'd0 : 32'd2);
        end
        step();
        chk("mid_blocked", 32'(valid_flit), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
